// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter and its phase decoder: ring width,
// decoder FSM states and reference code helpers.
package johnson_pkg;

  localparam int JC_N  = 8;
  localparam int JC_PW = $clog2(2 * JC_N);

  typedef enum logic [1:0] {HUNT, LOCKED, FAULT} state_t;

  // A legal code has at most one transition walking from bit 0 upward, and that
  // transition moves away from the value of bit 0.
  function automatic logic jc_legal(input logic [0:JC_N-1] code);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < JC_N - 1; i++)
      if (code[i] != code[i+1] && code[i+1] == code[0]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [JC_PW-1:0] jc_phase(input logic [0:JC_N-1] code);
    int ones;
    ones = 0;
    for (int i = 0; i < JC_N; i++) ones += int'(code[i]);
    if (code[0] || ones == 0) return JC_PW'(ones);
    return JC_PW'(2 * JC_N - ones);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase decode for one Johnson code word.
module johnson_code_check #(
  parameter int N = 8
) (
  input  logic [0:N-1]            code,
  output logic                    legal,
  output logic [$clog2(2*N)-1:0]  phase
);

  localparam int PW = $clog2(2 * N);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] ones;

  always_comb begin
    legal = 1'b1;
    ones  = '0;
    for (int i = 0; i < N; i++) ones = ones + CW'(code[i]);
    for (int i = 0; i < N - 1; i++)
      if (code[i] != code[i+1] && code[i+1] == code[0]) legal = 1'b0;
    // Filling half of the ring counts up in ones, draining half counts down.
    if (code[0] || ones == '0) phase = PW'(ones);
    else                        phase = PW'(2 * N - int'(ones));
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Validates a Johnson counter stream, decodes phase and one-hot strobes, locks
// after consecutive legal successor steps and counts faults while locked.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int N        = JC_N,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic [0:N-1]            jc,
  input  logic                    err_clr,
  output logic                    locked,
  output logic [$clog2(2*N)-1:0]  phase,
  output logic [2*N-1:0]          phase_oh,
  output logic                    wrap,
  output logic                    err_pulse,
  output logic [ERR_W-1:0]        err_cnt
);

  localparam int PW = $clog2(2 * N);
  localparam logic [2*N-1:0] OH_ONE = 1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] p);
    return (p == PW'(2 * N - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [0:N-1]     jc_p0, jc_p1;
  logic             cur_legal, prev_legal;
  logic [PW-1:0]    cur_phase, prev_phase;
  logic             good_step, fault;
  state_t           state, state_nxt;
  logic [3:0]       good_cnt, good_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [PW-1:0]    phase_p2;
  logic [2*N-1:0]   oh_p2;
  logic             wrap_p2, pulse_p2;
  logic [ERR_W-1:0] err_p2;

  johnson_code_check #(.N(N)) u_cur (
    .code  (jc_p0),
    .legal (cur_legal),
    .phase (cur_phase)
  );

  johnson_code_check #(.N(N)) u_prev (
    .code  (jc_p1),
    .legal (prev_legal),
    .phase (prev_phase)
  );

  // The counter has no enable, so a repeated code is as bad as a skipped one.
  assign good_step = cur_legal && prev_legal && (cur_phase == next_phase(prev_phase));

  always_comb begin
    state_nxt = state;
    good_nxt  = '0;
    fault     = 1'b0;
    case (state)
      HUNT: begin
        if (good_step) begin
          if (good_cnt == 4'(LOCK_CNT)) state_nxt = LOCKED;
          else                          good_nxt  = good_cnt + 4'd1;
        end
      end
      LOCKED: begin
        if (!good_step) begin
          fault     = 1'b1;
          state_nxt = FAULT;
        end
      end
      FAULT:   state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
    if (err_clr)    err_nxt = fault ? ERR_W'(1) : '0;
    else if (fault) err_nxt = sat_inc(err_p2);
    else            err_nxt = err_p2;
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      jc_p0    <= '0;
      jc_p1    <= '0;
      state    <= HUNT;
      good_cnt <= '0;
      phase_p2 <= '0;
      oh_p2    <= '0;
      wrap_p2  <= 1'b0;
      pulse_p2 <= 1'b0;
      err_p2   <= '0;
    end else begin
      // p0/p1: current and previous sample of the incoming code
      jc_p0    <= jc;
      jc_p1    <= jc_p0;
      state    <= state_nxt;
      good_cnt <= good_nxt;
      // p2: decoded outputs, blanked whenever the next state is not LOCKED
      phase_p2 <= (state_nxt == LOCKED) ? cur_phase : '0;
      oh_p2    <= (state_nxt == LOCKED) ? (OH_ONE << cur_phase) : '0;
      wrap_p2  <= (state == LOCKED) && good_step && (cur_phase == '0);
      pulse_p2 <= fault;
      err_p2   <= err_nxt;
    end
  end

  assign locked    = (state == LOCKED);
  assign phase     = phase_p2;
  assign phase_oh  = oh_p2;
  assign wrap      = wrap_p2;
  assign err_pulse = pulse_p2;
  assign err_cnt   = err_p2;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed scenarios plus randomized disturbance,
// checked each cycle against a table-driven behavioural model.
module tb_johnson_phase_decoder;

  localparam int N  = 8;
  localparam int LC = 3;
  localparam int EW = 8;
  localparam int P  = 2 * N;
  localparam int SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          r;
  logic [0:N-1]  jc;
  logic          err_clr;
  logic          locked;
  logic [3:0]    phase;
  logic [P-1:0]  phase_oh;
  logic          wrap;
  logic          err_pulse;
  logic [EW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int g = 0;

  johnson_phase_decoder #(.N(N), .LOCK_CNT(LC), .ERR_W(EW)) dut (
    .clk       (clk),
    .r         (r),
    .jc        (jc),
    .err_clr   (err_clr),
    .locked    (locked),
    .phase     (phase),
    .phase_oh  (phase_oh),
    .wrap      (wrap),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Code for ring position k: first k bits set while filling, then first k-N bits clear.
  function automatic logic [0:N-1] code_of(input int k);
    logic [0:N-1] c;
    for (int i = 0; i < N; i++) c[i] = (k <= N) ? (i < k) : (i >= k - N);
    return c;
  endfunction

  function automatic int ref_phase(input logic [0:N-1] c);
    for (int k = 0; k < P; k++) if (c === code_of(k)) return k;
    return -1;
  endfunction

  function automatic bit step_ok(input logic [0:N-1] cur, input logic [0:N-1] prv);
    int a, b;
    a = ref_phase(cur);
    b = ref_phase(prv);
    return (a >= 0) && (b >= 0) && (a == (b + 1) % P);
  endfunction

  // mode: 0 hunting, 1 locked, 2 one-cycle fault recovery
  function automatic int next_mode(input int mode, input int run, input bit ok);
    if (mode == 1) return ok ? 1 : 2;
    if (mode == 2) return 0;
    return (ok && run == LC) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  logic [0:N-1] m_jq, m_pq;
  int           m_mode, m_run, e_phase, e_cnt;
  logic [P-1:0] e_oh;
  logic         e_wrap, e_pulse;
  logic         m_ok, m_fault;
  int           m_nm, m_ph;

  assign m_ok    = step_ok(m_jq, m_pq);
  assign m_ph    = ref_phase(m_jq);
  assign m_nm    = next_mode(m_mode, m_run, m_ok);
  assign m_fault = (m_mode == 1) && !m_ok;

  always @(posedge clk or posedge r) begin
    if (r) begin
      m_jq <= '0; m_pq <= '0; m_mode <= 0; m_run <= 0;
      e_phase <= 0; e_oh <= '0; e_wrap <= 1'b0; e_pulse <= 1'b0; e_cnt <= 0;
    end else begin
      m_mode  <= m_nm;
      m_run   <= (m_mode == 0 && m_ok && m_run != LC) ? m_run + 1 : 0;
      e_phase <= (m_nm == 1) ? m_ph : 0;
      e_oh    <= (m_nm == 1) ? (P'(1) << m_ph) : '0;
      e_wrap  <= (m_mode == 1) && m_ok && (m_ph == 0);
      e_pulse <= m_fault;
      e_cnt   <= err_clr ? (m_fault ? 1 : 0)
               : m_fault ? ((e_cnt >= SAT) ? SAT : e_cnt + 1) : e_cnt;
      m_pq    <= m_jq;
      m_jq    <= jc;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("locked",    32'(locked),    32'(m_mode == 1));
      check("phase",     32'(phase),     e_phase);
      check("phase_oh",  32'(phase_oh),  32'(e_oh));
      check("wrap",      32'(wrap),      32'(e_wrap));
      check("err_pulse", 32'(err_pulse), 32'(e_pulse));
      check("err_cnt",   32'(err_cnt),   e_cnt);
    end
  end

  task automatic drive(input logic [0:N-1] c, input logic clr);
    @(negedge clk);
    jc = c;
    err_clr = clr;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive(code_of(g), 1'b0);
      g = (g + 1) % P;
    end
  endtask

  // kind: 0 illegal code, 1 skip one phase, 2 hold, 3 illegal with err_clr on the fault edge
  task automatic inject(input int kind);
    logic [0:N-1] ill;
    ill = 8'b10100000;
    case (kind)
      0, 3: begin drive(ill, 1'b0); g = (g + 1) % P; end
      1:    begin g = (g + 1) % P; drive(code_of(g), 1'b0); g = (g + 1) % P; end
      default: drive(code_of((g + P - 1) % P), 1'b0);
    endcase
    if (kind == 3) begin drive(code_of(g), 1'b1); g = (g + 1) % P; end
  endtask

  task automatic fault_watch(input int kind, input string name, input int exp_cnt);
    int pulses = 0;
    int low = 0;
    inject(kind);
    for (int i = 0; i < 10; i++) begin
      run(1);
      pulses += int'(err_pulse);
      low    += int'(!locked);
    end
    check({name, "_pulses"}, pulses, 1);
    check({name, "_lowcycles"}, low, 2 + LC);
    check({name, "_cnt"}, 32'(err_cnt), exp_cnt);
    check({name, "_relock"}, 32'(locked), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_at, ph_at, wraps, last, pick;
    logic clr;
    r = 1'b0; jc = '0; err_clr = 1'b0;
    #1 r = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_locked",   32'(locked),    0);
    check("rst_phase_oh", 32'(phase_oh),  0);
    check("rst_err_cnt",  32'(err_cnt),   0);
    check("rst_pulse",    32'(err_pulse), 0);
    cmp_en = 1'b1;

    // Lock from reset on the true sequence
    @(negedge clk);
    r = 1'b0; jc = code_of(0); g = 1;
    lock_at = 0; ph_at = -1;
    for (int c = 1; c <= 20 && lock_at == 0; c++) begin
      run(1);
      if (locked) begin lock_at = c; ph_at = int'(phase); end
    end
    check("lock_latency", lock_at, 2 + LC + 1);
    check("lock_phase", ph_at, 4);
    run(1);
    check("track_next", 32'(phase), 5);

    // Free run: wraps every ring period
    wraps = 0; last = -1;
    for (int i = 0; i < 64; i++) begin
      run(1);
      if (wrap) begin
        wraps++;
        check("wrap_phase", 32'(phase), 0);
        check("wrap_oh", 32'(phase_oh), 32'h0001);
        if (last >= 0) check("wrap_gap", i - last, 16);
        last = i;
      end
    end
    check("wrap_count", wraps, 4);

    fault_watch(0, "illegal", 1);
    while (g != 4) run(1);
    fault_watch(1, "skip", 2);
    while (g != 6) run(1);
    fault_watch(2, "hold", 3);

    for (int i = 0; i < 400 && err_cnt != EW'(SAT); i++) begin
      inject(2);
      run(10);
    end
    check("preload", 32'(err_cnt), SAT);
    fault_watch(0, "saturate", SAT);
    fault_watch(3, "clr_fault", 1);

    // Asynchronous reset while locked
    run(3);
    check("pre_rst_locked", 32'(locked), 1);
    @(negedge clk);
    #2 r = 1'b1;
    #1;
    check("arst_locked",   32'(locked),    0);
    check("arst_phase",    32'(phase),     0);
    check("arst_phase_oh", 32'(phase_oh),  0);
    check("arst_err_cnt",  32'(err_cnt),   0);
    check("arst_pulse",    32'(err_pulse), 0);
    repeat (2) @(negedge clk);
    r = 1'b0;
    for (int c = 0; c < 30 && !locked; c++) run(1);
    check("relock_after_rst", 32'(locked), 1);

    // Randomized disturbances
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 99);
      clr  = ($urandom_range(0, 99) < 3);
      if (pick < 3) begin
        drive(N'($urandom), clr); g = (g + 1) % P;
      end else if (pick < 5) begin
        g = (g + 1) % P; drive(code_of(g), clr); g = (g + 1) % P;
      end else if (pick < 7) begin
        drive(code_of((g + P - 1) % P), clr);
      end else if (pick == 7 && $urandom_range(0, 9) == 0) begin
        @(negedge clk);
        #2 r = 1'b1;
        @(negedge clk);
        r = 1'b0;
      end else begin
        drive(code_of(g), clr); g = (g + 1) % P;
      end
    end
    run(2);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
